// File: rtl/stage3_fence_pkg.sv
// Shared state encoding and defaults for the stage3 FENCE.I / SFENCE.VMA sequencer.
package stage3_fence_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_WAIT,
    I_WAIT,
    TLB_WAIT,
    DONE
  } fence_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;
  localparam int ASID_LENGTH_DEFAULT    = 9;

  function automatic logic is_wait(input fence_state_t s);
    return (s == D_WAIT) || (s == I_WAIT) || (s == TLB_WAIT);
  endfunction

endpackage

// File: rtl/stage3_fence_sequencer_watchdog.sv
// Per-state watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT_CYCLES-th one combinationally; TIMEOUT_CYCLES of 0 disables it.
module fence_watchdog #(
  parameter int CNT_W          = 13,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic             ARMED = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = ARMED & i_enable & (r_cnt == LIMIT);

endmodule

// File: rtl/stage3_fence_sequencer.sv
// Orders D$ writeback -> I$ invalidate -> ITLB/DTLB fence for FENCE.I / SFENCE.VMA in MEM.
// Pulses one cycle after acceptance; fence_done one cycle after the last done; stalls MEM meanwhile.
module stage3_fence_sequencer
  import stage3_fence_pkg::*;
#(
  parameter int ASID_LENGTH    = ASID_LENGTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 13
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   i_ifence_req,
  input  logic                   i_sfence_req,
  input  logic [ASID_LENGTH-1:0] i_req_asid,
  input  logic [31:0]            i_req_va,
  output logic                   o_dcache_flush,
  input  logic                   i_dflush_done,
  output logic                   o_icache_flush,
  input  logic                   i_iflush_done,
  output logic                   o_itlb_fence,
  output logic                   o_dtlb_fence,
  input  logic                   i_itlb_fence_done,
  input  logic                   i_dtlb_fence_done,
  output logic [ASID_LENGTH-1:0] o_fence_asid,
  output logic [31:0]            o_fence_va,
  output logic                   o_fence_stall,
  output logic                   o_fence_done,
  output logic                   o_timeout_err
);

  fence_state_t           r_state, w_next;
  logic                   r_dcache_flush, r_icache_flush, r_tlb_fence, r_fence_done;
  logic                   r_timeout_err, r_sfence_pend, r_abort;
  logic                   r_itlb_got, r_dtlb_got;
  logic [ASID_LENGTH-1:0] r_asid;
  logic [31:0]            r_va;

  logic w_any_req, w_in_wait, w_abort, w_expire, w_wd_clear;
  logic w_itlb_got, w_dtlb_got;
  logic w_pulse_d, w_pulse_i, w_pulse_t, w_pulse_done, w_latch;

  assign w_any_req  = i_ifence_req | i_sfence_req;
  assign w_in_wait  = is_wait(r_state);
  // A flushed instruction stays aborted for the rest of the current WAIT even if a new req appears.
  assign w_abort    = r_abort | ~w_any_req;
  assign w_itlb_got = r_itlb_got | i_itlb_fence_done;
  assign w_dtlb_got = r_dtlb_got | i_dtlb_fence_done;
  assign w_wd_clear = (w_next != r_state) | ~w_in_wait;

  fence_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_clear  (w_wd_clear),
    .i_enable (w_in_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next       = r_state;
    w_pulse_d    = 1'b0;
    w_pulse_i    = 1'b0;
    w_pulse_t    = 1'b0;
    w_pulse_done = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ifence_req) begin
          w_next    = D_WAIT;
          w_pulse_d = 1'b1;
          w_latch   = i_sfence_req;
        end else if (i_sfence_req) begin
          w_next    = TLB_WAIT;
          w_pulse_t = 1'b1;
          w_latch   = 1'b1;
        end
      end
      D_WAIT: begin
        if (i_dflush_done | w_expire) begin
          if (w_abort) begin
            w_next = IDLE;
          end else begin
            w_next    = I_WAIT;
            w_pulse_i = 1'b1;
          end
        end
      end
      I_WAIT: begin
        if (i_iflush_done | w_expire) begin
          if (w_abort) begin
            w_next = IDLE;
          end else if (r_sfence_pend) begin
            w_next    = TLB_WAIT;
            w_pulse_t = 1'b1;
          end else begin
            w_next       = DONE;
            w_pulse_done = 1'b1;
          end
        end
      end
      TLB_WAIT: begin
        if ((w_itlb_got & w_dtlb_got) | w_expire) begin
          if (w_abort) begin
            w_next = IDLE;
          end else begin
            w_next       = DONE;
            w_pulse_done = 1'b1;
          end
        end
      end
      DONE: begin
        if (!w_any_req) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= IDLE;
      r_dcache_flush <= 1'b0;
      r_icache_flush <= 1'b0;
      r_tlb_fence    <= 1'b0;
      r_fence_done   <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_sfence_pend  <= 1'b0;
      r_abort        <= 1'b0;
      r_itlb_got     <= 1'b0;
      r_dtlb_got     <= 1'b0;
      r_asid         <= '0;
      r_va           <= '0;
    end else begin
      r_state        <= w_next;
      r_dcache_flush <= w_pulse_d;
      r_icache_flush <= w_pulse_i;
      r_tlb_fence    <= w_pulse_t;
      r_fence_done   <= w_pulse_done;
      r_abort        <= w_in_wait & (w_next == r_state) & w_abort;
      if (w_expire) begin
        r_timeout_err <= 1'b1;
      end
      if (r_state == IDLE) begin
        r_sfence_pend <= i_ifence_req & i_sfence_req;
      end else if ((r_state == I_WAIT) && (w_next != I_WAIT)) begin
        r_sfence_pend <= 1'b0;
      end
      // TLB dones are sticky only while we keep waiting; any exit clears them.
      if ((r_state == TLB_WAIT) && (w_next == TLB_WAIT)) begin
        r_itlb_got <= w_itlb_got;
        r_dtlb_got <= w_dtlb_got;
      end else begin
        r_itlb_got <= 1'b0;
        r_dtlb_got <= 1'b0;
      end
      if (w_latch) begin
        r_asid <= i_req_asid;
        r_va   <= i_req_va;
      end
    end
  end

  assign o_dcache_flush = r_dcache_flush;
  assign o_icache_flush = r_icache_flush;
  assign o_itlb_fence   = r_tlb_fence;
  assign o_dtlb_fence   = r_tlb_fence;
  assign o_fence_done   = r_fence_done;
  assign o_timeout_err  = r_timeout_err;
  assign o_fence_asid   = r_asid;
  assign o_fence_va     = r_va;
  assign o_fence_stall  = w_any_req & (r_state != DONE);

endmodule

// File: tb/tb_stage3_fence_sequencer.sv
// Self-checking bench: responder drives done inputs relative to observed pulses;
// expected pulse/done/stall cycles are derived arithmetically from the sequencing rules.
module tb_stage3_fence_sequencer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        i_ifence_req = 1'b0, i_sfence_req = 1'b0;
  logic [8:0]  i_req_asid = '0;
  logic [31:0] i_req_va = '0;
  logic        i_dflush_done = 1'b0, i_iflush_done = 1'b0;
  logic        i_itlb_fence_done = 1'b0, i_dtlb_fence_done = 1'b0;
  logic        o_dcache_flush, o_icache_flush, o_itlb_fence, o_dtlb_fence;
  logic [8:0]  o_fence_asid;
  logic [31:0] o_fence_va;
  logic        o_fence_stall, o_fence_done, o_timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  stage3_fence_sequencer #(
    .ASID_LENGTH    (9),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (13)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .i_ifence_req      (i_ifence_req),
    .i_sfence_req      (i_sfence_req),
    .i_req_asid        (i_req_asid),
    .i_req_va          (i_req_va),
    .o_dcache_flush    (o_dcache_flush),
    .i_dflush_done     (i_dflush_done),
    .o_icache_flush    (o_icache_flush),
    .i_iflush_done     (i_iflush_done),
    .o_itlb_fence      (o_itlb_fence),
    .o_dtlb_fence      (o_dtlb_fence),
    .i_itlb_fence_done (i_itlb_fence_done),
    .i_dtlb_fence_done (i_dtlb_fence_done),
    .o_fence_asid      (o_fence_asid),
    .o_fence_va        (o_fence_va),
    .o_fence_stall     (o_fence_stall),
    .o_fence_done      (o_fence_done),
    .o_timeout_err     (o_timeout_err)
  );

  // Output vector order: {dflush, iflush, itlb, dtlb, fence_done, stall, timeout_err}
  function automatic logic [6:0] obs();
    return {o_dcache_flush, o_icache_flush, o_itlb_fence, o_dtlb_fence,
            o_fence_done, o_fence_stall, o_timeout_err};
  endfunction

  task automatic clear_dones();
    i_dflush_done = 1'b0; i_iflush_done = 1'b0;
    i_itlb_fence_done = 1'b0; i_dtlb_fence_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    nRST = 1'b0;
    i_ifence_req = 1'b0; i_sfence_req = 1'b0;
    clear_dones();
    repeat (3) @(negedge CLK);
    got = obs();
    n_checks++;
    if (got !== 7'b0) $display("FAIL reset_outputs got=%b exp=%b", got, 7'b0);
    else n_pass++;
    n_checks++;
    if ({o_fence_asid, o_fence_va} !== 41'd0)
      $display("FAIL reset_latches got=%h exp=0", {o_fence_asid, o_fence_va});
    else n_pass++;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_spurious_dones();
    logic [6:0] got;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      i_dflush_done = (k < 3); i_iflush_done = (k < 3);
      i_itlb_fence_done = (k < 3); i_dtlb_fence_done = (k < 3);
      @(negedge CLK);
      got = obs();
      n_checks++;
      if (got !== 7'b0) $display("FAIL spurious_done k=%0d got=%b exp=%b", k, got, 7'b0);
      else n_pass++;
    end
    clear_dones();
  endtask

  // Holds the request(s) until fence_done plus `hold` cycles, answering each pulse after its delay.
  task automatic run_fence(input string name, input bit do_i, input bit do_s,
                           input int dD, input int dI, input int dIt, input int dDt,
                           input int hold, input logic [8:0] asid, input logic [31:0] va);
    int e_d, e_i, e_t, e_done, last;
    int s_d, s_i, s_t;
    logic [6:0] got, exp;
    e_d = do_i ? 1 : -1;
    e_i = do_i ? 2 + dD : -1;
    e_t = do_s ? (do_i ? 3 + dD + dI : 1) : -1;
    e_done = do_s ? e_t + 1 + ((dIt > dDt) ? dIt : dDt) : e_i + 1 + dI;
    last = e_done + hold;
    s_d = -1000; s_i = -1000; s_t = -1000;
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge CLK); #1;
      i_ifence_req = do_i && (k <= last);
      i_sfence_req = do_s && (k <= last);
      i_req_asid = (k == 0) ? asid : 9'($urandom);
      i_req_va   = (k == 0) ? va : $urandom;
      if (o_dcache_flush) s_d = k;
      if (o_icache_flush) s_i = k;
      if (o_itlb_fence)   s_t = k;
      i_dflush_done     = (k == s_d + dD);
      i_iflush_done     = (k == s_i + dI);
      i_itlb_fence_done = (k == s_t + dIt);
      i_dtlb_fence_done = (k == s_t + dDt);
      @(negedge CLK);
      got = obs();
      exp = {k == e_d, k == e_i, k == e_t, k == e_t, k == e_done,
             (k <= last) && (k < e_done), 1'b0};
      n_checks++;
      if (got !== exp) $display("FAIL %s k=%0d got=%b exp=%b", name, k, got, exp);
      else n_pass++;
      if (do_s && k > e_t) begin
        n_checks++;
        if ({o_fence_asid, o_fence_va} !== {asid, va})
          $display("FAIL %s_latch k=%0d got=%h/%h exp=%h/%h", name, k,
                   o_fence_asid, o_fence_va, asid, va);
        else n_pass++;
      end
    end
    clear_dones();
  endtask

  task automatic test_ifence();
    run_fence("ifence", 1, 0, 4, 2, 0, 0, 0, 9'h0, 32'h0);
    run_fence("ifence_fast", 1, 0, 0, 0, 0, 0, 0, 9'h0, 32'h0);
  endtask

  task automatic test_sfence();
    run_fence("sfence", 0, 1, 0, 0, 6, 1, 0, 9'h05, 32'h8000_1000);
    run_fence("sfence_same", 0, 1, 0, 0, 2, 2, 1, 9'h1A3, 32'hDEAD_BEEF);
  endtask

  task automatic test_both();
    run_fence("both", 1, 1, 3, 1, 2, 4, 0, 9'h0F0, 32'h1234_5000);
  endtask

  task automatic test_hold();
    run_fence("hold", 1, 0, 1, 1, 0, 0, 10, 9'h0, 32'h0);
  endtask

  task automatic test_abort();
    logic [6:0] got, exp;
    // Request vanishes during D_WAIT: D$ completes, nothing further happens.
    for (int k = 0; k <= 8; k++) begin
      @(posedge CLK); #1;
      i_ifence_req = (k < 2);
      i_dflush_done = (k == 4);
      @(negedge CLK);
      got = obs();
      exp = {k == 1, 1'b0, 1'b0, 1'b0, 1'b0, k < 2, 1'b0};
      n_checks++;
      if (got !== exp) $display("FAIL abort k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
    // Re-raised while still aborting: new sequence starts only once back in IDLE.
    for (int k = 0; k <= 9; k++) begin
      @(posedge CLK); #1;
      i_ifence_req  = (k != 2) && (k <= 8);
      i_dflush_done = (k == 4) || (k == 6);
      i_iflush_done = (k == 7);
      @(negedge CLK);
      got = obs();
      exp = {(k == 1) || (k == 6), k == 7, 1'b0, 1'b0, k == 8, (k != 2) && (k < 8), 1'b0};
      n_checks++;
      if (got !== exp) $display("FAIL abort_reraise k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
    clear_dones();
  endtask

  task automatic test_random();
    int t;
    for (int n = 0; n < 25; n++) begin
      t = $urandom_range(0, 2);
      run_fence("random", t != 1, t != 0,
                $urandom_range(0, 8), $urandom_range(0, 8),
                $urandom_range(0, 8), $urandom_range(0, 8),
                $urandom_range(0, 3), 9'($urandom), $urandom);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] got, exp;
    for (int k = 0; k <= 20; k++) begin
      @(posedge CLK); #1;
      i_ifence_req  = (k <= 18);
      i_iflush_done = (k == 17);
      @(negedge CLK);
      got = obs();
      exp = {k == 1, k == 17, 1'b0, 1'b0, k == 18, k < 18, k >= 17};
      n_checks++;
      if (got !== exp) $display("FAIL timeout k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
    clear_dones();
  endtask

  task automatic test_reset_mid();
    logic [6:0] got, exp;
    for (int k = 0; k <= 3; k++) begin
      @(posedge CLK); #1;
      i_sfence_req = (k <= 2);
      i_req_asid = 9'h155;
      i_req_va = 32'hCAFE_0000;
      i_itlb_fence_done = (k == 2);
      if (k == 3) nRST = 1'b0;
      @(negedge CLK);
      got = obs();
      exp = {1'b0, 1'b0, k == 1, k == 1, 1'b0, k < 3, k < 3};
      n_checks++;
      if (got !== exp) $display("FAIL reset_mid k=%0d got=%b exp=%b", k, got, exp);
      else n_pass++;
    end
    n_checks++;
    if ({o_fence_asid, o_fence_va} !== 41'd0)
      $display("FAIL reset_mid_latch got=%h exp=0", {o_fence_asid, o_fence_va});
    else n_pass++;
    clear_dones();
    @(posedge CLK); #1;
    nRST = 1'b1;
    // A stale ITLB done would end this sequence early.
    run_fence("after_reset", 0, 1, 0, 0, 3, 0, 0, 9'h033, 32'h0000_4000);
  endtask

  initial begin
    test_reset();
    test_spurious_dones();
    test_ifence();
    test_sfence();
    test_both();
    test_hold();
    test_abort();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
